// File: rtl/edge_pulse_bank.sv
// Multi-channel edge detector: optional input synchroniser, per-channel
// rise/fall/both selection, retriggerable PULSE_LEN-cycle one-shot and sticky status.

module edge_pulse_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       shot_o,
    output logic       evt_o,
    output logic       ovr_o
);
    localparam int              CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic             sync;
    logic             prev;
    logic             rise;
    logic             fall;
    logic             hit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync = data_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] s;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s <= '0;
                end else begin
                    s[0] <= data_i;
                    for (int i = 1; i < SYNC_STAGES; i++) s[i] <= s[i-1];
                end
            end
            assign sync = s[SYNC_STAGES-1];
        end
    endgenerate

    // mode is deliberately unregistered: it only gates new hits, never a running pulse
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
    assign hit  = (mode_i[0] & rise) | (mode_i[1] & fall);

    always_comb begin
        cnt_nxt = cnt;
        if (hit)              cnt_nxt = LOAD;
        else if (cnt != '0)   cnt_nxt = cnt - ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev   <= 1'b0;
            cnt    <= '0;
            shot_o <= 1'b0;
        end else begin
            prev   <= sync;
            cnt    <= cnt_nxt;
            shot_o <= (cnt_nxt != '0);
        end
    end

    // a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_o <= 1'b0;
            ovr_o <= 1'b0;
        end else begin
            evt_o <= hit | (evt_o & ~clr_i);
            ovr_o <= (hit & (cnt != '0)) | (ovr_o & ~clr_i);
        end
    end
endmodule

module edge_pulse_bank #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     data_i,
    input  logic [2*NUM_CH-1:0]   mode_i,
    input  logic [NUM_CH-1:0]     clr_i,
    output logic [NUM_CH-1:0]     shot_o,
    output logic [NUM_CH-1:0]     evt_o,
    output logic [NUM_CH-1:0]     ovr_o
);
    // channel c takes data_i[c], mode_i[2c+1:2c], clr_i[c]
    edge_pulse_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .PULSE_LEN   (PULSE_LEN)
    ) u_ch [NUM_CH-1:0] (
        .clk    (clk),
        .reset  (reset),
        .data_i (data_i),
        .mode_i (mode_i),
        .clr_i  (clr_i),
        .shot_o (shot_o),
        .evt_o  (evt_o),
        .ovr_o  (ovr_o)
    );
endmodule

// File: tb/tb_edge_pulse_bank.sv
// Bench for edge_pulse_bank: five configurations share one stimulus; a cycle
// model feeds a scoreboard and scenario tasks check hand-derived timings.

module tb_edge_pulse_bank;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data = '0;
    logic [7:0] mode = '0;
    logic [3:0] clr = '0;

    logic [3:0] shot1, evt1, ovr1;   // NUM_CH=4 SYNC=2 LEN=1
    logic [3:0] shot3, evt3, ovr3;   // NUM_CH=4 SYNC=2 LEN=3
    logic [1:0] shot4, evt4, ovr4;   // NUM_CH=2 SYNC=0 LEN=4
    logic [0:0] shot8, evt8, ovr8;   // NUM_CH=1 SYNC=2 LEN=8
    logic [0:0] shot5, evt5, ovr5;   // NUM_CH=1 SYNC=2 LEN=5

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    edge_pulse_bank #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .data_i(data), .mode_i(mode), .clr_i(clr),
        .shot_o(shot1), .evt_o(evt1), .ovr_o(ovr1));
    edge_pulse_bank #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_LEN(3)) dut3 (
        .clk(clk), .reset(reset), .data_i(data), .mode_i(mode), .clr_i(clr),
        .shot_o(shot3), .evt_o(evt3), .ovr_o(ovr3));
    edge_pulse_bank #(.NUM_CH(2), .SYNC_STAGES(0), .PULSE_LEN(4)) dut4 (
        .clk(clk), .reset(reset), .data_i(data[1:0]), .mode_i(mode[3:0]), .clr_i(clr[1:0]),
        .shot_o(shot4), .evt_o(evt4), .ovr_o(ovr4));
    edge_pulse_bank #(.NUM_CH(1), .SYNC_STAGES(2), .PULSE_LEN(8)) dut8 (
        .clk(clk), .reset(reset), .data_i(data[0:0]), .mode_i(mode[1:0]), .clr_i(clr[0:0]),
        .shot_o(shot8), .evt_o(evt8), .ovr_o(ovr8));
    edge_pulse_bank #(.NUM_CH(1), .SYNC_STAGES(2), .PULSE_LEN(5)) dut5 (
        .clk(clk), .reset(reset), .data_i(data[0:0]), .mode_i(mode[1:0]), .clr_i(clr[0:0]),
        .shot_o(shot5), .evt_o(evt5), .ovr_o(ovr5));

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [4:0][3:0] shot;
        logic [4:0][3:0] evt;
        logic [4:0][3:0] ovr;
    } obs_t;

    obs_t sbq[$];

    function automatic int m_nch(int i);
        case (i) 0: return 4; 1: return 4; 2: return 2; default: return 1;
        endcase
    endfunction
    function automatic int m_sync(int i);
        return (i == 2) ? 0 : 2;
    endfunction
    function automatic int m_len(int i);
        case (i) 0: return 1; 1: return 3; 2: return 4; 3: return 8; default: return 5;
        endcase
    endfunction

    bit ms[5][4][4];
    bit mprev[5][4];
    int mcnt[5][4];
    bit mevt[5][4];
    bit movr[5][4];

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < 5; i++)
                    for (int c = 0; c < 4; c++) begin
                        for (int k = 0; k < 4; k++) ms[i][c][k] = 1'b0;
                        mprev[i][c] = 1'b0; mcnt[i][c] = 0;
                        mevt[i][c] = 1'b0;  movr[i][c] = 1'b0;
                    end
                sbq.delete();
            end else begin
                obs_t e;
                e = '0;
                for (int i = 0; i < 5; i++)
                    for (int c = 0; c < m_nch(i); c++) begin
                        bit syn, rs, fl, hit, ovs;
                        logic [1:0] md;
                        syn = (m_sync(i) == 0) ? data[c] : ms[i][c][m_sync(i)-1];
                        rs  = syn && !mprev[i][c];
                        fl  = !syn && mprev[i][c];
                        md  = mode[2*c +: 2];
                        hit = (md[0] && rs) || (md[1] && fl);
                        ovs = hit && (mcnt[i][c] > 0);
                        if (hit)                 mcnt[i][c] = m_len(i);
                        else if (mcnt[i][c] > 0) mcnt[i][c] = mcnt[i][c] - 1;
                        mevt[i][c] = hit || (mevt[i][c] && !clr[c]);
                        movr[i][c] = ovs || (movr[i][c] && !clr[c]);
                        mprev[i][c] = syn;
                        for (int k = 3; k > 0; k--) ms[i][c][k] = ms[i][c][k-1];
                        ms[i][c][0] = data[c];
                        e.shot[i][c] = (mcnt[i][c] > 0);
                        e.evt[i][c]  = mevt[i][c];
                        e.ovr[i][c]  = movr[i][c];
                    end
                sbq.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                obs_t e, a;
                e = sbq.pop_front();
                a.shot = {{3'b0, shot5}, {3'b0, shot8}, {2'b0, shot4}, shot3, shot1};
                a.evt  = {{3'b0, evt5},  {3'b0, evt8},  {2'b0, evt4},  evt3,  evt1};
                a.ovr  = {{3'b0, ovr5},  {3'b0, ovr8},  {2'b0, ovr4},  ovr3,  ovr1};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t shot got %h want %h, evt got %h want %h, ovr got %h want %h",
                             $time, a.shot, e.shot, a.evt, e.evt, a.ovr, e.ovr);
                end
            end
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic apply_reset();
        data = '0; mode = '0; clr = '0;
        @(negedge clk); #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({shot1, evt1, ovr1, shot3, evt3, ovr3, shot4, evt4, ovr4, shot8, evt8, ovr8, shot5, evt5, ovr5} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %b want all 0",
                     {shot1, evt1, ovr1, shot3, evt3, ovr3, shot4, evt4, ovr4, shot8, evt8, ovr8, shot5, evt5, ovr5});
        end
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({shot1, evt1, shot3, evt3} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want 0", {shot1, evt1, shot3, evt3});
        end
    endtask

    task automatic test_rise();
        apply_reset();
        mode = 8'h55;
        data[0] = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            @(negedge clk);
            vectors++;
            if (shot1 !== ((n == 2) ? 4'b0001 : 4'b0000)) begin
                miscompares++;
                $display("FAIL rise_shot n=%0d: got %b want %b", n, shot1, (n == 2) ? 4'b0001 : 4'b0000);
            end
            vectors++;
            if (evt1 !== ((n >= 2) ? 4'b0001 : 4'b0000)) begin
                miscompares++;
                $display("FAIL rise_evt n=%0d: got %b want %b", n, evt1, (n >= 2) ? 4'b0001 : 4'b0000);
            end
            vectors++;
            if (shot3[0] !== (n >= 2 && n <= 4)) begin
                miscompares++;
                $display("FAIL rise_len3 n=%0d: got %b want %b", n, shot3[0], (n >= 2 && n <= 4));
            end
        end
    endtask

    task automatic test_modes();
        apply_reset();
        mode = 8'b00_11_10_00;
        data = 4'b0111;
        for (int n = 0; n <= 24; n++) begin
            logic [3:0] exp;
            @(negedge clk);
            exp = '0;
            exp[2] = (n >= 2 && n <= 4) || (n >= 17 && n <= 19);
            exp[1] = (n >= 17 && n <= 19);
            vectors++;
            if (shot3 !== exp) begin
                miscompares++;
                $display("FAIL modes_shot n=%0d: got %b want %b", n, shot3, exp);
            end
            if (n == 14) data = 4'b0000;
        end
        vectors++;
        if (evt3 !== 4'b0110) begin
            miscompares++;
            $display("FAIL modes_evt: got %b want 0110", evt3);
        end
    endtask

    task automatic test_retrigger();
        apply_reset();
        mode = 8'h03;
        data[0] = 1'b1;
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            vectors++;
            if (shot4[0] !== (n <= 5)) begin
                miscompares++;
                $display("FAIL retrig_shot n=%0d: got %b want %b", n, shot4[0], (n <= 5));
            end
            vectors++;
            if (ovr4[0] !== (n >= 2)) begin
                miscompares++;
                $display("FAIL retrig_ovr n=%0d: got %b want %b", n, ovr4[0], (n >= 2));
            end
            if (n == 1) data[0] = 1'b0;
        end
    endtask

    task automatic test_clear_race();
        // evt4[0]/ovr4[0] are set from the retrigger scenario; pulse has ended
        mode = 8'h01;
        data[0] = 1'b1; clr[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if ({evt4[0], ovr4[0]} !== 2'b10) begin
            miscompares++;
            $display("FAIL clr_race: got evt,ovr=%b want 10", {evt4[0], ovr4[0]});
        end
        @(negedge clk);
        vectors++;
        if ({evt4[0], ovr4[0]} !== 2'b00) begin
            miscompares++;
            $display("FAIL clr_after: got evt,ovr=%b want 00", {evt4[0], ovr4[0]});
        end
        clr[0] = 1'b0; mode = 8'h03; data[0] = 1'b0;
        @(negedge clk);
        data[0] = 1'b1;
        @(negedge clk);
        data[0] = 1'b0; clr[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if ({evt4[0], ovr4[0]} !== 2'b11) begin
            miscompares++;
            $display("FAIL ovr_race: got evt,ovr=%b want 11", {evt4[0], ovr4[0]});
        end
        clr[0] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        mode = 8'h03;
        data[0] = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            @(negedge clk);
            if (n == 0) data[0] = 1'b0;
            vectors++;
            if ({shot3[0], ovr3[0]} !== {(n >= 2 && n <= 5), (n >= 3)}) begin
                miscompares++;
                $display("FAIL b2b_len3 n=%0d: got shot,ovr=%b want %b", n, {shot3[0], ovr3[0]},
                         {(n >= 2 && n <= 5), (n >= 3)});
            end
            vectors++;
            if ({shot1[0], ovr1[0]} !== {(n >= 2 && n <= 3), (n >= 3)}) begin
                miscompares++;
                $display("FAIL b2b_len1 n=%0d: got shot,ovr=%b want %b", n, {shot1[0], ovr1[0]},
                         {(n >= 2 && n <= 3), (n >= 3)});
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mode = 8'h01;
        data[0] = 1'b1;
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            vectors++;
            if (shot8[0] !== (n >= 2)) begin
                miscompares++;
                $display("FAIL rstmid_pre n=%0d: got %b want %b", n, shot8[0], (n >= 2));
            end
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({shot8[0], evt8[0], shot5[0], evt5[0], evt1[0]} !== 5'b0) begin
            miscompares++;
            $display("FAIL rstmid_drop: got %b want 00000", {shot8[0], evt8[0], shot5[0], evt5[0], evt1[0]});
        end
        @(negedge clk);
        #2 reset = 1'b0;
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            vectors++;
            if (shot8[0] !== (n >= 2)) begin
                miscompares++;
                $display("FAIL rstmid_post n=%0d: got %b want %b", n, shot8[0], (n >= 2));
            end
        end
    endtask

    task automatic test_mode_change();
        apply_reset();
        mode = 8'h01;
        data[0] = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            vectors++;
            if (shot5[0] !== (n >= 2 && n <= 6)) begin
                miscompares++;
                $display("FAIL modechg n=%0d: got %b want %b", n, shot5[0], (n >= 2 && n <= 6));
            end
            if (n == 3)  mode = 8'h00;
            if (n == 9)  data[0] = 1'b0;
            if (n == 13) data[0] = 1'b1;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            data = data ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            clr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
        end
        clr = '0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rise();
        test_modes();
        test_retrigger();
        test_clear_race();
        test_back_to_back();
        test_reset_mid();
        test_mode_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
